// File: rtl/timer_periph_pkg.sv
//------------------------------------------------------------------------------
// Module   : timer_periph_pkg
// Brief    : Register offsets, TCON bit layout and decode helper for timer_periph
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package timer_periph_pkg;

   localparam logic [31:0] c_th_off    = 32'h0000_0000;
   localparam logic [31:0] c_tl_off    = 32'h0000_0004;
   localparam logic [31:0] c_tcon_off  = 32'h0000_0008;

   localparam int          c_tcon_en   = 0;
   localparam int          c_tcon_ie   = 1;
   localparam int          c_tcon_is   = 2;
   localparam int          c_ovc_lsb   = 8;
   localparam int          c_ovc_msb   = 15;
   localparam logic [7:0]  c_ovc_max   = 8'hFF;

   localparam int          c_presc_w   = 16;

   typedef enum logic [1:0] {
      REG_NONE = 2'd0,
      REG_TH   = 2'd1,
      REG_TL   = 2'd2,
      REG_TCON = 2'd3
   } reg_sel_e;

   function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                            input logic [31:0] base);
      if (addr == base + c_th_off)        return REG_TH;
      else if (addr == base + c_tl_off)   return REG_TL;
      else if (addr == base + c_tcon_off) return REG_TCON;
      else                                return REG_NONE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
//------------------------------------------------------------------------------
// Module   : timer_prescaler
// Brief    : Divides clk by PRESCALE, emitting a one-cycle tick per period
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module timer_prescaler
   import timer_periph_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [c_presc_w-1:0] c_last = c_presc_w'(PRESCALE - 1);

   logic [c_presc_w-1:0] r_cnt;
   logic                 w_last;

   assign w_last = (r_cnt == c_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr || !en || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Combinational so the parent can arbitrate a tick against a same-cycle write
   assign tick = en & w_last;

endmodule

`default_nettype wire

// File: rtl/timer_periph.sv
//------------------------------------------------------------------------------
// Module   : timer_periph
// Brief    : Memory-mapped reload timer (TH/TL/TCON) with overflow interrupt
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module timer_periph
   import timer_periph_pkg::*;
#(
   parameter int          PRESCALE  = 1,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_wr,
   input  logic        ex_rd,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   output logic        irq
);

   logic [31:0] r_th;
   logic [31:0] r_tl;
   logic        r_en;
   logic        r_ie;
   logic        r_is;
   logic [7:0]  r_ovc;

   reg_sel_e    w_sel;
   logic        w_wr_th;
   logic        w_wr_tl;
   logic        w_wr_tcon;
   logic        w_is_clr;
   logic        w_tick;
   logic        w_tick_eff;
   logic        w_ovf;
   logic [31:0] w_tcon;

   assign w_sel     = decode_addr(Address, BASE_ADDR);
   assign w_wr_th   = ex_wr && (w_sel == REG_TH);
   assign w_wr_tl   = ex_wr && (w_sel == REG_TL);
   assign w_wr_tcon = ex_wr && (w_sel == REG_TCON);
   assign w_is_clr  = w_wr_tcon && Write_data[c_tcon_is];

   timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_presc (
      .clk   (clk),
      .reset (reset),
      .en    (r_en),
      .clr   (w_wr_tl | w_wr_tcon),
      .tick  (w_tick)
   );

   // A TL write or a TCON write that disables the timer swallows the tick
   assign w_tick_eff = w_tick && !w_wr_tl && !(w_wr_tcon && !Write_data[c_tcon_en]);
   assign w_ovf      = w_tick_eff && (r_tl == 32'hFFFF_FFFF);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_th  <= '0;
         r_tl  <= '0;
         r_en  <= 1'b0;
         r_ie  <= 1'b0;
         r_is  <= 1'b0;
         r_ovc <= '0;
      end else begin
         if (w_wr_th) begin
            r_th <= Write_data;
         end

         if (w_wr_tl) begin
            r_tl <= Write_data;
         end else if (w_ovf) begin
            r_tl <= r_th;
         end else if (w_tick_eff) begin
            r_tl <= r_tl + 32'd1;
         end

         if (w_wr_tcon) begin
            r_en <= Write_data[c_tcon_en];
            r_ie <= Write_data[c_tcon_ie];
         end

         // Overflow beats a same-cycle clear; the clear then restarts OVC at 1
         if (w_ovf) begin
            r_is <= 1'b1;
            if (w_is_clr) begin
               r_ovc <= 8'd1;
            end else if (r_ovc != c_ovc_max) begin
               r_ovc <= r_ovc + 8'd1;
            end
         end else if (w_is_clr) begin
            r_is  <= 1'b0;
            r_ovc <= '0;
         end
      end
   end

   always_comb begin
      w_tcon                        = '0;
      w_tcon[c_tcon_en]             = r_en;
      w_tcon[c_tcon_ie]             = r_ie;
      w_tcon[c_tcon_is]             = r_is;
      w_tcon[c_ovc_msb:c_ovc_lsb]   = r_ovc;
   end

   always_comb begin
      Read_data = '0;
      if (ex_rd) begin
         case (w_sel)
            REG_TH:   Read_data = r_th;
            REG_TL:   Read_data = r_tl;
            REG_TCON: Read_data = w_tcon;
            default:  Read_data = '0;
         endcase
      end
   end

   assign irq = r_ie & r_is;

endmodule

`default_nettype wire

// File: tb/tb_timer_periph.sv
//------------------------------------------------------------------------------
// Module   : tb_timer_periph
// Brief    : Self-checking bench for timer_periph (PRESCALE=1 and PRESCALE=4)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_timer_periph;

   localparam logic [31:0] c_base = 32'h4000_0000;
   localparam logic [31:0] c_th   = c_base + 32'h0;
   localparam logic [31:0] c_tl   = c_base + 32'h4;
   localparam logic [31:0] c_tcon = c_base + 32'h8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ex_wr = 1'b0;
   logic        ex_rd = 1'b0;
   logic [31:0] Address = '0;
   logic [31:0] Write_data = '0;
   logic [31:0] rd1;
   logic [31:0] rd4;
   logic        irq1;
   logic        irq4;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string       tag;
      logic [31:0] v;
      bit          p4;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   timer_periph #(.PRESCALE(1), .BASE_ADDR(c_base)) u1 (
      .clk(clk), .reset(reset), .ex_wr(ex_wr), .ex_rd(ex_rd),
      .Address(Address), .Write_data(Write_data), .Read_data(rd1), .irq(irq1)
   );

   timer_periph #(.PRESCALE(4), .BASE_ADDR(c_base)) u4 (
      .clk(clk), .reset(reset), .ex_wr(ex_wr), .ex_rd(ex_rd),
      .Address(Address), .Write_data(Write_data), .Read_data(rd4), .irq(irq4)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Issue a read; the expected word is queued first, then popped against the bus
   task automatic rd_chk(input string tag, input logic [31:0] addr,
                         input logic [31:0] v, input bit p4);
      exp_t e;
      sb.push_back('{tag: tag, v: v, p4: p4});
      Address = addr;
      ex_rd   = 1'b1;
      #1;
      e = sb.pop_front();
      chk(e.tag, e.p4 ? rd4 : rd1, e.v);
      ex_rd = 1'b0;
   endtask

   // Called just after a negedge; the write lands on the following posedge
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      Address    = addr;
      Write_data = data;
      ex_wr      = 1'b1;
      @(negedge clk);
      ex_wr      = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      ex_wr = 1'b0;
      ex_rd = 1'b0;
      reset = 1'b0;
      cycles(2);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      // Reset values, plus writes that must be ignored
      do_reset();
      rd_chk("rst_th",   c_th,   32'h0, 0);
      rd_chk("rst_tl",   c_tl,   32'h0, 0);
      rd_chk("rst_tcon", c_tcon, 32'h0, 0);
      chk("rst_irq", {31'b0, irq1}, 32'h0);
      Address = c_th; Write_data = 32'hDEAD_BEEF; ex_wr = 1'b0;
      cycles(1);
      wr(c_base + 32'hC, 32'h1234_5678);
      wr(32'h5000_0000, 32'h3);
      rd_chk("nowr_th",   c_th,   32'h0, 0);
      rd_chk("unmap_tcon", c_tcon, 32'h0, 0);
      wr(c_th, 32'hA5A5_0001);
      Address = c_th; ex_rd = 1'b0; #1;
      chk("rd_idle", rd1, 32'h0);
      rd_chk("th_wr", c_th, 32'hA5A5_0001, 0);

      // PRESCALE=1 increment then overflow reload
      do_reset();
      wr(c_th,   32'hFFFF_FFF0);
      wr(c_tl,   32'hFFFF_FFFE);
      wr(c_tcon, 32'h3);
      rd_chk("p1_tl0", c_tl, 32'hFFFF_FFFE, 0);
      cycles(1);
      rd_chk("p1_tl1", c_tl, 32'hFFFF_FFFF, 0);
      cycles(1);
      rd_chk("p1_tl2",   c_tl,   32'hFFFF_FFF0, 0);
      rd_chk("p1_tcon",  c_tcon, 32'h0000_0107, 0);
      chk("p1_irq", {31'b0, irq1}, 32'h1);

      // PRESCALE=4 cadence and freeze on disable
      do_reset();
      wr(c_tcon, 32'h1);
      rd_chk("p4_t0", c_tl, 32'h0, 1);
      cycles(3);
      rd_chk("p4_t3", c_tl, 32'h0, 1);
      cycles(1);
      rd_chk("p4_t4", c_tl, 32'h1, 1);
      cycles(3);
      rd_chk("p4_t7", c_tl, 32'h1, 1);
      cycles(1);
      rd_chk("p4_t8", c_tl, 32'h2, 1);
      wr(c_tcon, 32'h0);
      cycles(10);
      rd_chk("p4_frz", c_tl, 32'h2, 1);

      // TL write beats a coincident overflow tick
      do_reset();
      wr(c_tl,   32'hFFFF_FFFF);
      wr(c_tcon, 32'h1);
      wr(c_tl,   32'h0000_0100);
      rd_chk("tlw_tl",   c_tl,   32'h0000_0100, 0);
      rd_chk("tlw_tcon", c_tcon, 32'h0000_0001, 0);

      // Overflow beats a coincident IS clear; EN=0 write drops a tick; W1C
      do_reset();
      wr(c_th,   32'hFFFF_FFFF);
      wr(c_tl,   32'hFFFF_FFFF);
      wr(c_tcon, 32'h1);
      cycles(5);
      rd_chk("ov5_tcon", c_tcon, 32'h0000_0505, 0);
      wr(c_tcon, 32'h7);
      rd_chk("clr_race", c_tcon, 32'h0000_0107, 0);
      chk("clr_race_irq", {31'b0, irq1}, 32'h1);
      wr(c_tcon, 32'h2);
      rd_chk("en0_drop", c_tcon, 32'h0000_0106, 0);
      wr(c_tcon, 32'h4);
      rd_chk("w1c_tcon", c_tcon, 32'h0, 0);
      chk("w1c_irq", {31'b0, irq1}, 32'h0);

      // OVC saturation, then asynchronous reset mid-count
      do_reset();
      wr(c_th,   32'hFFFF_FFFF);
      wr(c_tl,   32'hFFFF_FFFF);
      wr(c_tcon, 32'h3);
      cycles(300);
      rd_chk("sat_tcon", c_tcon, 32'h0000_FF07, 0);
      #1;
      reset = 1'b0;
      rd_chk("arst_th",   c_th,   32'h0, 0);
      rd_chk("arst_tl",   c_tl,   32'h0, 0);
      rd_chk("arst_tcon", c_tcon, 32'h0, 0);
      chk("arst_irq", {31'b0, irq1}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
